// File: rtl/demux8_seq_if.sv
// Bus bundle for demux8_seq: write-side inputs and the registered lane/status outputs.
interface demux8_seq_if;
  logic       d_in;
  logic       valid;
  logic [2:0] s;
  logic       auto_mode;
  logic       clear;
  logic [7:0] y;
  logic [7:0] strobe;
  logic [2:0] ptr;
  logic       full;

  // Driver side: supplies writes and observes lane state.
  modport master (
    output d_in, valid, s, auto_mode, clear,
    input  y, strobe, ptr, full
  );

  // Demux side: consumes writes and drives lane state.
  modport slave (
    input  d_in, valid, s, auto_mode, clear,
    output y, strobe, ptr, full
  );
endinterface

// File: rtl/demux8_seq.sv
// 1-to-8 sequential demultiplexer. Bits are written either to an addressed
// lane (s) or to the next lane of an auto-fill sequence (ptr). Every output
// comes straight from a register.
module demux8_seq (
  input  logic          clk,
  input  logic          reset,
  demux8_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [2:0] ptr_q, next_ptr;
  logic [7:0] y_q, next_y;
  logic [7:0] strobe_q, next_strobe;
  logic [2:0] lane;
  logic [7:0] lane_mask;
  logic       accept;

  // Lane chosen for this cycle's write and whether the write is taken.
  always_comb begin
    lane      = bus.auto_mode ? ptr_q : bus.s;
    lane_mask = 8'h01 << lane;
    // Auto writes are dropped once all eight lanes are filled; addressed
    // writes are always taken. clear overrides any write.
    accept    = bus.valid && !bus.clear && (!bus.auto_mode || state != FULL);
  end

  // Next-state, pointer, lane and strobe computation.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    next_state  = state;
    next_ptr    = ptr_q;
    next_y      = y_q;
    next_strobe = 8'h00;

    if (bus.clear) begin
      next_state = IDLE;
      next_ptr   = 3'd0;
    end else if (accept) begin
      next_y      = bus.d_in ? (y_q | lane_mask) : (y_q & ~lane_mask);
      next_strobe = lane_mask;
      if (bus.auto_mode) begin
        next_ptr   = ptr_q + 3'd1;
        next_state = (ptr_q == 3'd7) ? FULL : FILL;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      // NOTE: the lane bits are reset explicitly because they are visible outputs, not scratch storage.
      state    <= IDLE;
      ptr_q    <= 3'd0;
      y_q      <= 8'h00;
      strobe_q <= 8'h00;
    end else begin
      state    <= next_state;
      ptr_q    <= next_ptr;
      y_q      <= next_y;
      strobe_q <= next_strobe;
    end
  end

  assign bus.y      = y_q;
  assign bus.strobe = strobe_q;
  assign bus.ptr    = ptr_q;
  assign bus.full   = (state == FULL);

endmodule

// File: tb/tb_demux8_seq.sv
// Directed self-checking bench for demux8_seq.
module tb_demux8_seq;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  demux8_seq_if bus ();

  demux8_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, take one rising edge, settle just after it.
  task automatic step(input logic v, input logic am, input logic [2:0] sel,
                      input logic d, input logic clr);
    bus.valid     = v;
    bus.auto_mode = am;
    bus.s         = sel;
    bus.d_in      = d;
    bus.clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] y_e, input logic [7:0] st_e,
                           input logic [2:0] p_e, input logic f_e);
    check({tag, ".y"},      bus.y,             y_e);
    check({tag, ".strobe"}, bus.strobe,        st_e);
    check({tag, ".ptr"},    {5'd0, bus.ptr},   {5'd0, p_e});
    check({tag, ".full"},   {7'd0, bus.full},  {7'd0, f_e});
  endtask

  logic [7:0] fill_bits;
  logic [7:0] y_exp;

  initial begin
    // Reset with active-looking inputs; outputs must not depend on them.
    reset = 1'b1;
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
    step(1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    check_all("reset", 8'h00, 8'h00, 3'd0, 1'b0);
    reset = 1'b0;

    // Addressed writes to lanes 3 and 6.
    step(1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
    check_all("addr_s3", 8'h08, 8'h08, 3'd0, 1'b0);
    step(1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    check_all("addr_s6", 8'h48, 8'h40, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    check_all("idle", 8'h48, 8'h00, 3'd0, 1'b0);

    // Auto fill of all eight lanes with 1,0,1,1,0,0,1,0 (lane 0 first).
    fill_bits = 8'b0100_1101;
    y_exp     = 8'h48;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 3'd0, fill_bits[i], 1'b0);
      y_exp[i] = fill_bits[i];
      check_all($sformatf("fill%0d", i), y_exp, 8'h01 << i, 3'(i + 1), (i == 7));
    end
    check("fill_final_y", bus.y, 8'h4D);

    // FULL: auto write dropped, addressed write accepted.
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    check_all("full_auto_drop", 8'h4D, 8'h00, 3'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check_all("full_addr", 8'h4C, 8'h01, 3'd0, 1'b1);

    // clear returns to IDLE; refill lanes 0..3 with ones; clear beats a write.
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check_all("clear", 8'h4C, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    check_all("refill4", 8'h4F, 8'h08, 3'd4, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
    check_all("clear_vs_write", 8'h4F, 8'h00, 3'd0, 1'b0);

    // Auto to ptr=3, addressed write to lane 7, resume auto at lane 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    check_all("auto3", 8'h48, 8'h04, 3'd3, 1'b0);
    step(1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
    check_all("mid_addr_s7", 8'hC8, 8'h80, 3'd3, 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    check_all("no_valid", 8'hC8, 8'h00, 3'd3, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    check_all("resume_lane3", 8'hC0, 8'h08, 3'd4, 1'b0);

    // Reset mid-fill at ptr=5 with a write pending.
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    check_all("auto_ptr5", 8'hD0, 8'h10, 3'd5, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    check_all("reset_mid", 8'h00, 8'h00, 3'd0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
    check_all("post_reset_auto", 8'h01, 8'h01, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux8_seq.md
DEMUX8_SEQ -- requirements
Module: demux8_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 d_in  input  1  data bit to distribute.
REQ-005 valid  input  1  d_in is a write this cycle when high.
REQ-006 s  input  3  lane select for addressed mode; s[0] is the LSB.
REQ-007 auto_mode  input  1  1 = lane taken from internal pointer; 0 = lane taken from s.
REQ-008 clear  input  1  synchronous restart of the auto-fill sequence.
REQ-009 y  output  8  registered lane holding bits; y[i] is the last bit written to lane i.
REQ-010 strobe  output  8  registered one-hot write pulse; strobe[i]=1 for exactly one cycle after a write to lane i.
REQ-011 ptr  output  3  current auto-fill pointer.
REQ-012 full  output  1  high while all 8 lanes have been filled in auto mode.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-014 FSM states SHALL be IDLE (ptr=0, full=0), FILL (ptr 1..7, full=0) and FULL (ptr=0, full=1).
REQ-015 Write index SHALL be s when auto_mode=0 and ptr when auto_mode=1, sampled in the same cycle as valid.
REQ-016 Addressed write (valid=1, auto_mode=0, clear=0): y[s] <= d_in, other y bits unchanged, ptr/state unchanged; accepted in every state including FULL.
REQ-017 Auto write (valid=1, auto_mode=1, clear=0) in IDLE/FILL: y[ptr] <= d_in, ptr <= ptr+1; IDLE->FILL on first write; FILL->FULL when the write hits ptr=7 (ptr wraps to 0, full <= 1).
REQ-018 Auto write in FULL SHALL be dropped: y, ptr, full unchanged and strobe=0.
REQ-019 strobe SHALL be 8'h00 in every cycle that does not follow an accepted write; it SHALL never have more than one bit set.
REQ-020 Write latency SHALL be one cycle: y and strobe reflect the write at edge k during the cycle after edge k.
REQ-021 clear=1 (reset=0) SHALL force ptr=0, full=0, state=IDLE; y is retained; strobe=0.
REQ-022 clear and valid in the same cycle: clear wins and the write is dropped.
REQ-023 Switching auto_mode mid-fill SHALL NOT alter ptr; auto-fill resumes from the held ptr.
REQ-024 valid=0 SHALL leave y, ptr, state unchanged and drive strobe=0.

Reset
REQ-025 reset=1 at a rising edge SHALL set y=8'h00, strobe=8'h00, ptr=3'd0, full=0, state=IDLE, overriding clear and valid.
REQ-026 reset asserted mid-fill (e.g. ptr=5) SHALL discard progress; the first auto write after release goes to lane 0.
REQ-027 Outputs after reset SHALL be independent of input values during reset.

Verification
REQ-028 Reset, then addressed writes d_in=1 to s=3 and s=6 -> y=8'h48; strobe=8'h08 then 8'h40 on consecutive cycles; ptr=0, full=0.
REQ-029 Auto mode, 8 consecutive writes of bits 1,0,1,1,0,0,1,0 -> y=8'h4D, ptr sequence 1..7,0, full=1 after the 8th write, strobe walks 01,02,...,80.
REQ-030 In FULL, auto write d_in=0 -> y stays 8'h4D, strobe=0; addressed write d_in=0 to s=0 -> y=8'h4C, strobe=8'h01, full stays 1.
REQ-031 clear and valid (auto, d_in=1) in the same cycle while ptr=4 -> ptr=0, full=0, y unchanged, strobe=0.
REQ-032 Auto fill to ptr=3, switch to addressed write s=7, return to auto -> next auto write lands in lane 3 and ptr=4.
REQ-033 reset asserted with ptr=5 and valid=1 -> y=8'h00, ptr=0, full=0, strobe=0 next cycle.
